// File: rtl/tube_write_arbiter.sv
// Shares the write-only 7-segment tube port between the CPU (req0) and a status source (req1).
// Each write is held for HOLD_CYCLES clocks. Define TUBE_ARB_SHADOW_EN to add shadow readback.
module tube_write_arbiter #(
    parameter int HOLD_CYCLES = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        disp_en,
    input  logic        req0_valid,
    input  logic [2:0]  req0_addr,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [2:0]  req1_addr,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        tube_we,
    output logic        tube_cs,
    output logic [2:0]  tube_addr,
    output logic [15:0] tube_data,
    output logic        busy,
    output logic        addr_err
`ifdef TUBE_ARB_SHADOW_EN
    ,
    input  logic [2:0]  rd_addr,
    output logic [15:0] rd_data
`endif
);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_lastGrant;
    logic             r_req0Ready;
    logic             r_req1Ready;
    logic             r_tubeWe;
    logic             r_tubeCs;
    logic [2:0]       r_tubeAddr;
    logic [15:0]      r_tubeData;
    logic             r_busy;
    logic             r_addrErr;

    logic             w_pick1;
    logic [2:0]       w_addr;
    logic [15:0]      w_data;
    logic             w_legal;
    logic             w_grant;

    // On a tie, the requester that did not win last time gets the port.
    assign w_pick1 = req1_valid & (~req0_valid | ~r_lastGrant);
    assign w_addr  = w_pick1 ? req1_addr : req0_addr;
    assign w_data  = w_pick1 ? req1_data : req0_data;
    assign w_legal = (w_addr == 3'd0) | (w_addr == 3'd2) | (w_addr == 3'd4);
    assign w_grant = (r_state == IDLE) & r_tubeCs & (req0_valid | req1_valid);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_lastGrant <= 1'b1;
            r_req0Ready <= 1'b0;
            r_req1Ready <= 1'b0;
            r_tubeWe    <= 1'b0;
            r_tubeCs    <= 1'b0;
            r_tubeAddr  <= '0;
            r_tubeData  <= '0;
            r_busy      <= 1'b0;
            r_addrErr   <= 1'b0;
        end else begin
            r_tubeCs    <= disp_en;
            r_req0Ready <= 1'b0;
            r_req1Ready <= 1'b0;
            r_addrErr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_req0Ready <= ~w_pick1;
                        r_req1Ready <= w_pick1;
                        r_lastGrant <= w_pick1;
                        // Illegal addresses are acknowledged but never reach the tube.
                        if (w_legal) begin
                            r_tubeAddr <= w_addr;
                            r_tubeData <= w_data;
                            r_tubeWe   <= 1'b1;
                            r_busy     <= 1'b1;
                            r_count    <= CNT_W'(HOLD_CYCLES - 1);
                            r_state    <= HOLD;
                        end else begin
                            r_addrErr <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (r_count == '0) begin
                        r_tubeWe <= 1'b0;
                        r_state  <= GAP;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                GAP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req0_ready = r_req0Ready;
    assign req1_ready = r_req1Ready;
    assign tube_we    = r_tubeWe;
    assign tube_cs    = r_tubeCs;
    assign tube_addr  = r_tubeAddr;
    assign tube_data  = r_tubeData;
    assign busy       = r_busy;
    assign addr_err   = r_addrErr;

`ifdef TUBE_ARB_SHADOW_EN
    logic [15:0] r_shadowLow;
    logic [15:0] r_shadowHigh;
    logic [15:0] r_shadowSpecial;

    // The tube cannot be read, so every legal write is mirrored here for the CPU.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadowLow     <= '0;
            r_shadowHigh    <= '0;
            r_shadowSpecial <= '0;
        end else if (w_grant && w_legal) begin
            case (w_addr)
                3'd0:    r_shadowLow     <= w_data;
                3'd2:    r_shadowHigh    <= w_data;
                default: r_shadowSpecial <= w_data;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            3'd0:    rd_data = r_shadowLow;
            3'd2:    rd_data = r_shadowHigh;
            3'd4:    rd_data = r_shadowSpecial;
            default: rd_data = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_tube_write_arbiter.sv
// Self-checking bench for tube_write_arbiter: vector table, hand-written corner sequences,
// and randomized traffic against a time-since-grant reference model.
module tb_tube_write_arbiter;

    localparam int HOLD = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        disp_en;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_addr, req1_addr;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        tube_we, tube_cs, busy, addr_err;
    logic [2:0]  tube_addr;
    logic [15:0] tube_data;
`ifdef TUBE_ARB_SHADOW_EN
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
`endif

    int passCount  = 0;
    int checkCount = 0;

    always #5 clock = ~clock;

    tube_write_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(7)) dut (
        .clock(clock), .reset(reset), .disp_en(disp_en),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .tube_we(tube_we), .tube_cs(tube_cs), .tube_addr(tube_addr), .tube_data(tube_data),
        .busy(busy), .addr_err(addr_err)
`ifdef TUBE_ARB_SHADOW_EN
        , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
    );

    typedef struct {
        logic        v0;
        logic [2:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic [2:0]  a1;
        logic [15:0] d1;
        logic        eR0;
        logic        eR1;
        logic        eWe;
        logic        eErr;
        logic [2:0]  eAddr;
        logic [15:0] eData;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] outVec();
        return {7'd0, req0_ready, req1_ready, tube_we, tube_cs, busy, addr_err, tube_addr, tube_data};
    endfunction

    task automatic applyStimulus(input logic v0, input logic [2:0] a0, input logic [15:0] d0,
                                 input logic v1, input logic [2:0] a1, input logic [15:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        disp_en = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        checkOutput("reset_outputs", outVec(), 32'd0);
        reset = 1'b0;
        tick();
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 100);
        checkOutput(name, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [2:0] randAddr();
        int r = int'($urandom_range(7));
        if (r < 2) return 3'd0;
        if (r < 4) return 3'd2;
        if (r < 6) return 3'd4;
        return 3'($urandom_range(7));
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   weCount, busyLowAt;
        logic stable, seen;
        int   mSince, mLast;
        logic mCs, eR0, eR1, eErr, pick1;
        logic [2:0]  mAddr, gAddr;
        logic [15:0] mData, gData;

        vecs[0] = '{1'b1, 3'd0, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h1234};
        vecs[1] = '{1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd4, 16'h5555, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 16'h5555};
        vecs[2] = '{1'b1, 3'd2, 16'h0F0F, 1'b1, 3'd0, 16'hF0F0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0F0F};
        vecs[3] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0F0F};
        vecs[4] = '{1'b1, 3'd7, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0F0F};
        vecs[5] = '{1'b1, 3'd4, 16'hCAFE, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 16'hCAFE};
        vecs[6] = '{1'b1, 3'd0, 16'h0001, 1'b1, 3'd2, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0002};

`ifdef TUBE_ARB_SHADOW_EN
        rd_addr = 3'd0;
`endif
        applyReset();
        disp_en = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            tick();
            checkOutput($sformatf("vec%0d", i),
                        {9'd0, req0_ready, req1_ready, tube_we, addr_err, tube_addr, tube_data},
                        {9'd0, vecs[i].eR0, vecs[i].eR1, vecs[i].eWe, vecs[i].eErr, vecs[i].eAddr, vecs[i].eData});
            applyStimulus(0, 0, 0, 0, 0, 0);
            waitIdle($sformatf("vec%0d_idle", i));
        end

        // Write stretch: tube_we high for exactly HOLD clocks, busy drops one GAP clock later.
        applyStimulus(1, 3'd0, 16'h1234, 0, 0, 0);
        tick();
        checkOutput("hold_grant", {12'd0, req0_ready, tube_we, tube_addr, tube_data}, {12'd0, 1'b1, 1'b1, 3'd0, 16'h1234});
        applyStimulus(0, 0, 0, 0, 0, 0);
        weCount = 1; busyLowAt = -1; stable = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (tube_we) weCount++;
            if (!busy && busyLowAt < 0) busyLowAt = i;
            if (tube_addr != 3'd0 || tube_data != 16'h1234) stable = 1'b0;
        end
        checkOutput("hold_we_count", weCount, HOLD);
        checkOutput("hold_busy_low_at", busyLowAt, HOLD + 1);
        checkOutput("hold_addr_data_stable", {31'd0, stable}, 32'd1);

        // Display disabled: the request waits, then wins two clocks after enable.
        disp_en = 1'b0;
        tick();
        applyStimulus(1, 3'd2, 16'h5A5A, 0, 0, 0);
        seen = 1'b0;
        repeat (200) begin
            tick();
            if (req0_ready || tube_we) seen = 1'b1;
        end
        checkOutput("cs_off_no_grant", {31'd0, seen}, 32'd0);
        checkOutput("cs_off_cs_low", {31'd0, tube_cs}, 32'd0);
        disp_en = 1'b1;
        tick();
        checkOutput("cs_on_edge1", {30'd0, req0_ready, tube_cs}, {30'd0, 1'b0, 1'b1});
        tick();
        checkOutput("cs_on_edge2", {30'd0, req0_ready, tube_we}, {30'd0, 1'b1, 1'b1});
        applyStimulus(0, 0, 0, 0, 0, 0);
        waitIdle("cs_on_idle");

        // Asynchronous reset in the middle of a hold.
        applyStimulus(0, 0, 0, 1, 3'd4, 16'h7777);
        tick();
        checkOutput("rst_pre_grant", {30'd0, req1_ready, tube_we}, {30'd0, 1'b1, 1'b1});
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (10) tick();
        checkOutput("rst_in_hold", {31'd0, tube_we}, 32'd1);
        #2 reset = 1'b1;
        #1 checkOutput("rst_async_clear", outVec(), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        applyStimulus(1, 3'd0, 16'h0BAD, 1, 3'd2, 16'h600D);
        tick();
        checkOutput("rst_tie_req0", {28'd0, req0_ready, req1_ready, tube_we, addr_err}, {28'd0, 4'b1010});
        applyStimulus(0, 0, 0, 0, 0, 0);
        waitIdle("rst_tie_idle");
        applyStimulus(0, 0, 0, 1, 3'd2, 16'h4242);
        tick();
        checkOutput("rst_req1", {12'd0, req1_ready, tube_we, tube_addr, tube_data}, {12'd0, 1'b1, 1'b1, 3'd2, 16'h4242});
        applyStimulus(0, 0, 0, 0, 0, 0);
        waitIdle("rst_req1_idle");

`ifdef TUBE_ARB_SHADOW_EN
        applyStimulus(1, 3'd4, 16'hABCD, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        rd_addr = 3'd4;
        #1 checkOutput("shadow_special", {16'd0, rd_data}, 32'h0000ABCD);
        rd_addr = 3'd2;
        #1 checkOutput("shadow_high", {16'd0, rd_data}, 32'h00004242);
        rd_addr = 3'd1;
        #1 checkOutput("shadow_illegal", {16'd0, rd_data}, 32'd0);
        waitIdle("shadow_idle");
`endif

        // Randomized traffic against a time-since-last-write model.
        applyReset();
        mSince = HOLD + 1; mLast = 1; mCs = 1'b0; mAddr = '0; mData = '0;
        disp_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!req0_valid && $urandom_range(3) == 0) begin
                req0_valid = 1'b1; req0_addr = randAddr(); req0_data = 16'($urandom);
            end
            if (!req1_valid && $urandom_range(3) == 0) begin
                req1_valid = 1'b1; req1_addr = randAddr(); req1_data = 16'($urandom);
            end
            if ($urandom_range(99) == 0) disp_en = ~disp_en;

            eR0 = 1'b0; eR1 = 1'b0; eErr = 1'b0;
            if (mSince > HOLD && mCs && (req0_valid || req1_valid)) begin
                pick1 = req1_valid && (!req0_valid || mLast == 0);
                gAddr = pick1 ? req1_addr : req0_addr;
                gData = pick1 ? req1_data : req0_data;
                if (pick1) eR1 = 1'b1;
                else       eR0 = 1'b1;
                mLast = pick1 ? 1 : 0;
                if (gAddr == 3'd0 || gAddr == 3'd2 || gAddr == 3'd4) begin
                    mSince = 0; mAddr = gAddr; mData = gData;
                end else begin
                    eErr = 1'b1;
                end
            end else if (mSince <= HOLD) begin
                mSince++;
            end
            mCs = disp_en;

            tick();
            checkOutput($sformatf("rand%0d", cyc), outVec(),
                        {7'd0, eR0, eR1, (mSince < HOLD), mCs, (mSince <= HOLD), eErr, mAddr, mData});
            if (eR0) req0_valid = 1'b0;
            if (eR1) req1_valid = 1'b0;
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
